// File: rtl/uart_echo_tester.sv
// Sends NUM_BYTES 8N1 frames, checks each echo is the case-swapped byte, and counts bad or missing echoes.
// One byte outstanding at a time; the busy/done/pass/err_count outputs summarise the current run.
module uart_echo_tester #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int NUM_BYTES    = 26,
    parameter int FIRST_BYTE   = 65,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rx,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, FINISH} state_t;

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_HALF = CW'(HALF);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_BYTES - 1);
    localparam logic [7:0]    FIRST_B  = 8'(FIRST_BYTE);

    state_t state_q, state_d;

    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic          tx_q;
    logic [8:0]    tx_shift_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic          rx_act_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_stop_q;
    logic          timed_out_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    idx_q, cur_byte_q;
    logic [7:0]    err_q, err_d;
    logic          pass_q;

    logic          start_ok, enter_send, rx_tick, frame_done, timeout, mismatch;
    logic [7:0]    next_byte;

    function automatic logic [7:0] echo_of(input logic [7:0] b);
        if (b >= 8'd65 && b <= 8'd90)  return b + 8'd32;
        if (b >= 8'd97 && b <= 8'd122) return b - 8'd32;
        return b;
    endfunction

    assign start_ok   = start && (state_q == IDLE || state_q == FINISH);
    assign enter_send = (state_d == SEND) && (state_q != SEND);
    assign next_byte  = start_ok ? FIRST_B : FIRST_B + idx_q + 8'd1;
    // Start bit is confirmed half a bit after the edge, data/stop a whole bit apart after that.
    assign rx_tick    = rx_act_q && (rx_cnt_q == ((rx_bit_q == 4'd0) ? BIT_HALF : BIT_FULL));
    assign frame_done = (state_q == WAIT) && rx_tick && (rx_bit_q == 4'd9);
    assign timeout    = (state_q == WAIT) && !frame_done && (to_cnt_q == TO_LAST);
    assign mismatch   = timed_out_q || !rx_stop_q || (rx_shift_q != echo_of(cur_byte_q));

    assign tx        = tx_q;
    assign pass      = pass_q;
    assign err_count = err_q;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = SEND;
            SEND: begin
                busy = 1'b1;
                if (tx_bit_q == 4'd10) state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (frame_done || timeout) state_d = CHECK;
            end
            CHECK: begin
                busy    = 1'b1;
                state_d = (idx_q == LAST_IDX) ? FINISH : SEND;
            end
            FINISH: begin
                done = 1'b1;
                if (start) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (start_ok)
            err_d = 8'd0;
        else if (state_q == CHECK && mismatch && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_q      <= 8'd0;
            pass_q     <= 1'b0;
            idx_q      <= 8'd0;
            cur_byte_q <= 8'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            pass_q  <= (state_d == FINISH) && (err_d == 8'd0);
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            if (start_ok)
                idx_q <= 8'd0;
            else if (state_q == CHECK && state_d == SEND)
                idx_q <= idx_q + 8'd1;
            if (enter_send)
                cur_byte_q <= next_byte;
        end
    end

    // Transmitter: tx_bit_q counts start, 8 data and stop bits; 10 is the one-cycle tail before WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q       <= 1'b1;
            tx_shift_q <= 9'h1FF;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
        end else if (enter_send) begin
            tx_q       <= 1'b0;
            tx_shift_q <= {1'b1, next_byte};
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
        end else if (state_q == SEND && tx_bit_q != 4'd10) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q   <= '0;
                tx_bit_q   <= tx_bit_q + 4'd1;
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end else begin
            tx_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act_q    <= 1'b0;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= 8'd0;
            rx_stop_q   <= 1'b0;
            timed_out_q <= 1'b0;
            to_cnt_q    <= '0;
        end else if (state_q != WAIT) begin
            rx_act_q <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            to_cnt_q    <= to_cnt_q + 1'b1;
            timed_out_q <= timeout;
            if (!rx_act_q) begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_act_q <= 1'b1;
                    rx_cnt_q <= CW'(1);
                    rx_bit_q <= 4'd0;
                end
            end else if (rx_tick) begin
                rx_cnt_q <= CW'(1);
                case (rx_bit_q)
                    4'd0: begin
                        if (rx_s2_q) rx_act_q <= 1'b0;
                        else         rx_bit_q <= 4'd1;
                    end
                    4'd9: begin
                        rx_stop_q <= rx_s2_q;
                        rx_act_q  <= 1'b0;
                    end
                    default: begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 4'd1;
                    end
                endcase
            end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end
        end
    end

endmodule
